// File: rtl/isp_control_if.sv
// Pixel-path bundle between the camera/host side and the ISP sequencer.
// Latency: none (wires only).
// Backpressure: read_data from the host freezes pixel acceptance.
interface isp_control_if #(
    parameter int ADDR_W = 32
);
    logic              new_frame;
    logic              data_valid;
    logic              read_data;
    logic [ADDR_W-1:0] frame_buffer_base_adr;
    logic [ADDR_W-1:0] write_address;
    logic              write_enable;
    logic              wb_enable;
    logic              cc_enable;

    modport master (
        output new_frame, data_valid, read_data, frame_buffer_base_adr,
        input  write_address, write_enable, wb_enable, cc_enable
    );

    modport slave (
        input  new_frame, data_valid, read_data, frame_buffer_base_adr,
        output write_address, write_enable, wb_enable, cc_enable
    );
endinterface

// File: rtl/isp_control.sv
// ISP pixel-path sequencer: wb/cc stage enables and frame-buffer write strobes/addresses.
// Latency: accept -> wb_enable 1 cycle, cc_enable 2 cycles, write_enable 3 cycles.
// Backpressure: read_data stalls acceptance only; in-flight pixels still complete.
module isp_control #(
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_STEP    = 4,
    parameter int ADDR_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    isp_control_if.slave  bus
);
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] next_adr;
    logic [ADDR_W-1:0] s1_adr;
    logic [ADDR_W-1:0] s2_adr;
    logic [ADDR_W-1:0] wr_adr;
    logic              s1_vld;
    logic              s2_vld;
    logic              s3_vld;
    logic              frame_start;
    logic              pix_accept;
    logic              last_pix;

    // A frame start wins over a same-cycle pixel, which is dropped.
    assign frame_start = bus.new_frame && !bus.read_data;
    assign pix_accept  = (state == CAPTURE) && bus.data_valid && !bus.read_data && !bus.new_frame;
    assign last_pix    = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = CAPTURE;
        end else begin
            case (state)
                CAPTURE: if (pix_accept && last_pix) state_nxt = DRAIN;
                // s3 drains on this same edge, so only s1/s2 need to be empty.
                DRAIN:   if (!s1_vld && !s2_vld) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            next_adr <= '0;
            s1_adr   <= '0;
            s2_adr   <= '0;
            wr_adr   <= '0;
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            s3_vld   <= 1'b0;
        end else begin
            state  <= state_nxt;
            s1_vld <= pix_accept;
            s2_vld <= s1_vld && !frame_start;
            s3_vld <= s2_vld && !frame_start;
            if (pix_accept) begin
                s1_adr <= next_adr;
            end
            s2_adr <= s1_adr;
            // Address only moves with a live write so it holds between strobes.
            if (s2_vld && !frame_start) begin
                wr_adr <= s2_adr;
            end
            if (frame_start) begin
                pix_cnt  <= '0;
                next_adr <= bus.frame_buffer_base_adr;
            end else if (pix_accept) begin
                pix_cnt  <= pix_cnt + 1'b1;
                next_adr <= next_adr + ADDR_W'(ADDR_STEP);
            end
        end
    end

    assign bus.wb_enable     = s1_vld;
    assign bus.cc_enable     = s2_vld;
    assign bus.write_enable  = s3_vld;
    assign bus.write_address = wr_adr;
endmodule

// File: tb/tb_isp_control.sv
// Bench for isp_control: directed scenarios plus random traffic against a queue-based model.
module tb_isp_control;
    localparam int FP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    isp_control_if #(.ADDR_W(32)) bus ();

    isp_control #(
        .FRAME_PIXELS(FP),
        .ADDR_STEP   (4),
        .ADDR_W      (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          t;
        logic [31:0] a;
    } pix_t;

    pix_t        q[$];
    logic [31:0] wlog[$];
    int          e = 0;
    logic [31:0] m_base = '0;
    int          m_k = 0;
    bit          m_cap = 1'b0;
    logic [31:0] m_wa = '0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare outputs.
    task automatic step();
        logic exp_wb, exp_cc, exp_we;
        @(posedge clk);
        e++;
        if (!reset) begin
            q.delete();
            m_cap = 1'b0;
            m_k   = 0;
            m_wa  = '0;
        end else if (bus.new_frame && !bus.read_data) begin
            m_base = bus.frame_buffer_base_adr;
            m_k    = 0;
            m_cap  = 1'b1;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].t >= e - 2) q.delete(i);
        end else if (m_cap && bus.data_valid && !bus.read_data) begin
            q.push_back('{e, m_base + 32'(m_k) * 32'd4});
            m_k++;
            if (m_k == FP) m_cap = 1'b0;
        end
        #1;
        exp_wb = 1'b0;
        exp_cc = 1'b0;
        exp_we = 1'b0;
        foreach (q[i]) begin
            if (q[i].t == e)     exp_wb = 1'b1;
            if (q[i].t == e - 1) exp_cc = 1'b1;
            if (q[i].t == e - 2) begin
                exp_we = 1'b1;
                m_wa   = q[i].a;
            end
        end
        while (q.size() > 0 && q[0].t < e - 2) void'(q.pop_front());
        chk("wb_enable",     32'(bus.wb_enable),    32'(exp_wb));
        chk("cc_enable",     32'(bus.cc_enable),    32'(exp_cc));
        chk("write_enable",  32'(bus.write_enable), 32'(exp_we));
        chk("write_address", bus.write_address,     m_wa);
        if (bus.write_enable) wlog.push_back(bus.write_address);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic nf, input logic dv, input logic rd);
        bus.new_frame  = nf;
        bus.data_valid = dv;
        bus.read_data  = rd;
    endtask

    task automatic start_frame(input logic [31:0] base);
        bus.frame_buffer_base_adr = base;
        drive(1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_log(input string tag, input logic [31:0] exp[$]);
        chk({tag, "_count"}, 32'(wlog.size()), 32'(exp.size()));
        foreach (exp[i])
            chk(tag, (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF, exp[i]);
        wlog.delete();
    endtask

    initial begin
        reset = 1'b0;
        bus.frame_buffer_base_adr = '0;
        drive(1'b0, 1'b1, 1'b0);

        // Reset held with data_valid high, then released without a frame start.
        steps(2);
        reset = 1'b1;
        steps(3);
        chk("idle_wa", bus.write_address, 32'h0);
        drive(1'b0, 1'b0, 1'b0);

        // Basic three-pixel frame.
        wlog.delete();
        start_frame(32'h1000_0000);
        drive(1'b0, 1'b1, 1'b0);
        steps(3);
        drive(1'b0, 1'b0, 1'b0);
        steps(5);
        chk("basic_hold", bus.write_address, 32'h1000_0008);
        check_log("basic", '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008});

        // read_data stall mid-frame.
        start_frame(32'h3000_0000);
        drive(1'b0, 1'b1, 1'b0);
        steps(2);
        drive(1'b0, 1'b1, 1'b1);
        steps(2);
        drive(1'b0, 1'b1, 1'b0);
        steps(2);
        drive(1'b0, 1'b0, 1'b0);
        steps(5);
        check_log("stall", '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 32'h3000_000C});

        // Frame end: six offered, four written, then idle ignores data_valid.
        start_frame(32'h4000_0000);
        drive(1'b0, 1'b1, 1'b0);
        steps(6);
        drive(1'b0, 1'b0, 1'b0);
        steps(4);
        drive(1'b0, 1'b1, 1'b0);
        steps(4);
        drive(1'b0, 1'b0, 1'b0);
        steps(2);
        check_log("frame_end", '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_000C});

        // Abort with two pixels in flight; same-cycle data_valid dropped.
        start_frame(32'h5000_0000);
        drive(1'b0, 1'b1, 1'b0);
        steps(2);
        bus.frame_buffer_base_adr = 32'h2000_0000;
        drive(1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        steps(5);
        check_log("abort", '{32'h2000_0000});

        // Address wrap-around.
        start_frame(32'hFFFF_FFF8);
        drive(1'b0, 1'b1, 1'b0);
        steps(3);
        drive(1'b0, 1'b0, 1'b0);
        steps(5);
        check_log("wrap", '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000});

        // Asynchronous reset mid-frame clears outputs immediately.
        start_frame(32'h6000_0000);
        drive(1'b0, 1'b1, 1'b0);
        steps(3);
        reset = 1'b0;
        #2;
        chk("arst_wb", 32'(bus.wb_enable),    32'h0);
        chk("arst_cc", 32'(bus.cc_enable),    32'h0);
        chk("arst_we", 32'(bus.write_enable), 32'h0);
        chk("arst_wa", bus.write_address,     32'h0);
        steps(2);
        reset = 1'b1;
        steps(4);
        wlog.delete();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.new_frame  = ($urandom_range(99) < 4);
            bus.data_valid = ($urandom_range(99) < 70);
            bus.read_data  = ($urandom_range(99) < 15);
            if (bus.new_frame) bus.frame_buffer_base_adr = $urandom;
            step();
        end
        drive(1'b0, 1'b0, 1'b0);
        steps(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
